// File: rtl/ysyx_22050612_ifu_if.sv
// Fetch-stage bundle: instruction memory port, decode handshake, redirect and halt status.
// The master side is the fetch unit; the slave side is memory/decode/execute.
interface ysyx_22050612_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch: one outstanding imem read, small PC-tagged queue toward decode, redirect flush.
// Optional macro IFU_EBREAK_HALT_EN stops fetching after an ebreak word is queued.
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_22050612_ifu_if.master  io_ifu
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

  state_e             r_state;
  logic               r_started;
  logic [63:0]        r_fetch_pc;
  logic [63:0]        r_pending_pc;
  logic [31:0]        r_q_inst [QUEUE_DEPTH];
  logic [63:0]        r_q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic        w_halted;
  logic        w_full;
  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_push;
  logic        w_pop;
  logic [63:0] w_redir_pc;

  assign w_full      = (r_count == CNT_W'(QUEUE_DEPTH));
  assign w_req_valid = r_started && (r_state == S_IDLE) && !w_full &&
                       !io_ifu.redirect_valid && !w_halted;
  assign w_req_fire  = w_req_valid && io_ifu.imem_req_ready;
  // A redirect voids both the response capture and the decode pop of that cycle.
  assign w_push      = (r_state == S_WAIT) && io_ifu.imem_resp_valid && !io_ifu.redirect_valid;
  assign w_pop       = (r_count != '0) && io_ifu.inst_ready && !io_ifu.redirect_valid;
  assign w_redir_pc  = io_ifu.redirect_pc & ~64'h3;

  assign io_ifu.imem_req_valid = w_req_valid;
  assign io_ifu.imem_req_addr  = r_fetch_pc;
  assign io_ifu.inst_valid     = (r_count != '0);
  assign io_ifu.inst           = r_q_inst[r_rd_ptr];
  assign io_ifu.inst_pc        = r_q_pc[r_rd_ptr];
  assign io_ifu.halted         = w_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_started    <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= RESET_PC;
    end else begin
      r_started <= 1'b1;
      if (io_ifu.redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        case (r_state)
          S_WAIT:  r_state <= io_ifu.imem_resp_valid ? S_IDLE : S_DRAIN;
          S_DRAIN: if (io_ifu.imem_resp_valid) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_IDLE: if (w_req_fire) begin
            r_pending_pc <= r_fetch_pc;
            r_fetch_pc   <= r_fetch_pc + 64'd4;
            r_state      <= S_WAIT;
          end
          S_WAIT, S_DRAIN: if (io_ifu.imem_resp_valid) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (io_ifu.redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= io_ifu.imem_resp_data;
      r_q_pc[r_wr_ptr]   <= r_pending_pc;
    end
  end

`ifdef IFU_EBREAK_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  logic r_halted;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_halted <= 1'b0;
    else if (io_ifu.redirect_valid)                      r_halted <= 1'b0;
    else if (w_push && io_ifu.imem_resp_data == EBREAK)  r_halted <= 1'b1;
  end
  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Randomized and directed bench for the fetch unit; a per-cycle memory model answers
// each accepted read and expected PC streams come from sequential-fetch rules.
module tb_ysyx_22050612_ifu;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050612_ifu_if bus();

  ysyx_22050612_ifu #(.RESET_PC(RST_PC), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .io_ifu(bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // memory model state
  bit          mem_pend = 0;
  int          mem_delay = 0;
  logic [63:0] mem_addr = '0;
  int          lat_min = 1, lat_max = 1;
  logic [63:0] ebreak_addr = 64'h1;
  int          proto_err = 0;

  // per-cycle observations
  logic        o_rv, o_fire, o_iv, o_pop, o_resp, o_redir, o_halted;
  logic [63:0] o_addr, o_pc;
  logic [31:0] o_inst;

  function automatic logic [31:0] memf(input logic [63:0] a);
    if (a == ebreak_addr) return EBREAK;
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Samples one cycle at the falling edge, then advances the memory model.
  task automatic cycle();
    @(negedge clk);
    o_rv     = bus.imem_req_valid;
    o_addr   = bus.imem_req_addr;
    o_fire   = o_rv && bus.imem_req_ready;
    o_iv     = bus.inst_valid;
    o_inst   = bus.inst;
    o_pc     = bus.inst_pc;
    o_pop    = o_iv && bus.inst_ready;
    o_resp   = bus.imem_resp_valid;
    o_redir  = bus.redirect_valid;
    o_halted = bus.halted;
    if (o_resp) mem_pend = 0;
    if (o_fire) begin
      if (mem_pend) proto_err++;
      mem_pend  = 1;
      mem_delay = $urandom_range(lat_max, lat_min);
      mem_addr  = o_addr;
    end
    @(posedge clk); #1;
    bus.imem_resp_valid = 1'b0;
    if (mem_pend) begin
      mem_delay--;
      if (mem_delay <= 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memf(mem_addr);
      end
    end
  endtask

  task automatic clear_inputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    mem_pend = 0;
    lat_min = 1; lat_max = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got=%b want=0", bus.imem_req_valid); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got=%b want=0", bus.inst_valid); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b want=0", bus.halted); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL prestart_req_valid got=%b want=0", bus.imem_req_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid got=%b want=1", bus.imem_req_valid); end
    n_cmp++; if (bus.imem_req_addr !== RST_PC) begin n_err++; $display("FAIL first_req_addr got=%h want=%h", bus.imem_req_addr, RST_PC); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int nf = 0, np = 0;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (o_fire) begin
        n_cmp++; if (o_addr !== RST_PC + 64'(4 * nf)) begin n_err++; $display("FAIL stream_addr got=%h want=%h", o_addr, RST_PC + 64'(4 * nf)); end
        nf++;
      end
      if (o_pop) begin
        n_cmp++; if (o_pc !== RST_PC + 64'(4 * np) || o_inst !== memf(RST_PC + 64'(4 * np))) begin
          n_err++; $display("FAIL stream_inst got=%h/%h want=%h/%h", o_pc, o_inst, RST_PC + 64'(4 * np), memf(RST_PC + 64'(4 * np)));
        end
        np++;
      end
    end
    n_cmp++; if (nf != 8) begin n_err++; $display("FAIL stream_fires got=%0d want=8", nf); end
    n_cmp++; if (np != 7) begin n_err++; $display("FAIL stream_pops got=%0d want=7", np); end
  endtask

  task automatic test_backpressure();
    int nf = 0, np = 0;
    bit got_fire = 0;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (o_fire) nf++;
      if (o_iv) begin
        n_cmp++; if (o_pc !== RST_PC || o_inst !== memf(RST_PC)) begin n_err++; $display("FAIL bp_head_hold got=%h/%h want=%h/%h", o_pc, o_inst, RST_PC, memf(RST_PC)); end
      end
    end
    n_cmp++; if (nf != 2) begin n_err++; $display("FAIL bp_fires got=%0d want=2", nf); end
    n_cmp++; if (o_rv !== 1'b0) begin n_err++; $display("FAIL bp_req_blocked got=%b want=0", o_rv); end
    bus.inst_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (o_pop && np < 2) begin
        n_cmp++; if (o_pc !== RST_PC + 64'(4 * np)) begin n_err++; $display("FAIL bp_drain_pc got=%h want=%h", o_pc, RST_PC + 64'(4 * np)); end
        np++;
      end
      if (o_fire && !got_fire) begin
        got_fire = 1;
        n_cmp++; if (o_addr !== RST_PC + 64'd8) begin n_err++; $display("FAIL bp_resume_addr got=%h want=%h", o_addr, RST_PC + 64'd8); end
      end
    end
    n_cmp++; if (np != 2 || !got_fire) begin n_err++; $display("FAIL bp_resume got=%0d/%0d want=2/1", np, got_fire); end
  endtask

  task automatic test_req_stall();
    int nf = 0;
    do_reset();
    bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++; if (o_rv !== 1'b1 || o_addr !== RST_PC) begin n_err++; $display("FAIL stall_hold got=%b/%h want=1/%h", o_rv, o_addr, RST_PC); end
    end
    bus.imem_req_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      if (o_fire) nf++;
    end
    n_cmp++; if (nf != 1) begin n_err++; $display("FAIL stall_accept got=%0d want=1", nf); end
  endtask

  task automatic test_redirect_wait();
    bit got_fire = 0, got_pop = 0;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    lat_min = 3; lat_max = 3;
    cycle();
    n_cmp++; if (o_fire !== 1'b1) begin n_err++; $display("FAIL rw_first_fire got=%b want=1", o_fire); end
    lat_min = 1; lat_max = 1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_1002;
    cycle();
    n_cmp++; if (o_rv !== 1'b0) begin n_err++; $display("FAIL rw_no_req_on_redirect got=%b want=0", o_rv); end
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 20 && !got_pop; c++) begin
      cycle();
      if (o_fire && !got_fire) begin
        got_fire = 1;
        n_cmp++; if (o_addr !== 64'h8000_1000) begin n_err++; $display("FAIL rw_new_addr got=%h want=80001000", o_addr); end
      end
      if (o_pop) begin
        got_pop = 1;
        n_cmp++; if (o_pc !== 64'h8000_1000 || o_inst !== memf(64'h8000_1000)) begin
          n_err++; $display("FAIL rw_new_inst got=%h/%h want=80001000/%h", o_pc, o_inst, memf(64'h8000_1000));
        end
      end
    end
    n_cmp++; if (!got_pop) begin n_err++; $display("FAIL rw_timeout got=0 want=1"); end
  endtask

  task automatic test_redirect_same_cycle();
    bit got_pop = 0;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    bus.inst_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_2000;
    cycle();
    n_cmp++; if (o_resp !== 1'b1 || o_iv !== 1'b1) begin n_err++; $display("FAIL rs_setup got=%b/%b want=1/1", o_resp, o_iv); end
    bus.redirect_valid = 1'b0;
    cycle();
    n_cmp++; if (o_iv !== 1'b0) begin n_err++; $display("FAIL rs_flushed got=%b want=0", o_iv); end
    n_cmp++; if (o_rv !== 1'b1 || o_addr !== 64'h8000_2000) begin n_err++; $display("FAIL rs_new_req got=%b/%h want=1/80002000", o_rv, o_addr); end
    for (int c = 0; c < 10 && !got_pop; c++) begin
      cycle();
      if (o_pop) begin
        got_pop = 1;
        n_cmp++; if (o_pc !== 64'h8000_2000) begin n_err++; $display("FAIL rs_first_pc got=%h want=80002000", o_pc); end
      end
    end
    n_cmp++; if (!got_pop) begin n_err++; $display("FAIL rs_timeout got=0 want=1"); end
  endtask

  task automatic test_random();
    logic [63:0] exp_req, exp_inst, tgt, p_addr, p_pc;
    logic [31:0] p_inst;
    logic        p_rv = 0, p_rdy = 0, p_iv = 0, p_irdy = 0, p_redir = 0;
    int npop = 0, nhalt = 0;
    do_reset();
    exp_req = RST_PC; exp_inst = RST_PC;
    p_addr = '0; p_pc = '0; p_inst = '0;
    lat_min = 1; lat_max = 4;
    for (int c = 0; c < 3000; c++) begin
      bus.imem_req_ready = ($urandom_range(9, 0) < 7);
      bus.inst_ready     = ($urandom_range(9, 0) < 6);
      bus.redirect_valid = ($urandom_range(99, 0) < 3);
      if ($urandom_range(3, 0) == 0) tgt = {32'hFFFF_FFFF, 32'hFFFF_FFF0 | 32'($urandom_range(15, 0))};
      else                           tgt = {$urandom, $urandom};
      bus.redirect_pc = tgt;
      cycle();
      if (o_halted) nhalt++;
      if (o_redir) begin
        n_cmp++; if (o_rv !== 1'b0) begin n_err++; $display("FAIL rnd_req_on_redirect got=%b want=0", o_rv); end
        exp_req  = tgt & ~64'h3;
        exp_inst = tgt & ~64'h3;
      end else begin
        if (o_fire) begin
          n_cmp++; if (o_addr !== exp_req) begin n_err++; $display("FAIL rnd_addr got=%h want=%h", o_addr, exp_req); end
          exp_req += 64'd4;
        end
        if (o_pop) begin
          n_cmp++; if (o_pc !== exp_inst || o_inst !== memf(exp_inst)) begin
            n_err++; $display("FAIL rnd_inst got=%h/%h want=%h/%h", o_pc, o_inst, exp_inst, memf(exp_inst));
          end
          exp_inst += 64'd4;
          npop++;
        end
        if (p_rv && !p_rdy) begin
          n_cmp++; if (o_rv !== 1'b1 || o_addr !== p_addr) begin n_err++; $display("FAIL rnd_req_hold got=%b/%h want=1/%h", o_rv, o_addr, p_addr); end
        end
        if (p_iv && !p_irdy && !p_redir) begin
          n_cmp++; if (o_iv !== 1'b1 || o_pc !== p_pc || o_inst !== p_inst) begin
            n_err++; $display("FAIL rnd_head_hold got=%b/%h/%h want=1/%h/%h", o_iv, o_pc, o_inst, p_pc, p_inst);
          end
        end
      end
      p_rv = o_rv; p_rdy = bus.imem_req_ready; p_addr = o_addr;
      p_iv = o_iv; p_irdy = bus.inst_ready; p_pc = o_pc; p_inst = o_inst; p_redir = o_redir;
    end
    bus.redirect_valid = 1'b0;
    n_cmp++; if (proto_err != 0) begin n_err++; $display("FAIL rnd_one_outstanding got=%0d want=0", proto_err); end
    n_cmp++; if (npop <= 100) begin n_err++; $display("FAIL rnd_progress got=%0d want=>100", npop); end
    n_cmp++; if (nhalt != 0) begin n_err++; $display("FAIL rnd_halted got=%0d want=0", nhalt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_async got=%b/%b want=0/0", bus.imem_req_valid, bus.inst_valid);
    end
    clear_inputs();
    @(posedge clk); #1;
  endtask

`ifdef IFU_EBREAK_HALT_EN
  task automatic test_halt();
    int nf = 0, after = -1;
    logic [31:0] ebw = '0;
    ebreak_addr = RST_PC + 64'd8;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    for (int c = 0; c < 30 && after != 3; c++) begin
      cycle();
      if (o_fire) nf++;
      if (after >= 0) after++;
      if (o_pop && o_pc == RST_PC + 64'd8) begin ebw = o_inst; after = 0; end
    end
    n_cmp++; if (ebw !== EBREAK) begin n_err++; $display("FAIL halt_ebreak_delivered got=%h want=%h", ebw, EBREAK); end
    n_cmp++; if (o_halted !== 1'b1 || o_rv !== 1'b0) begin n_err++; $display("FAIL halt_state got=%b/%b want=1/0", o_halted, o_rv); end
    n_cmp++; if (nf != 3) begin n_err++; $display("FAIL halt_fires got=%0d want=3", nf); end
    ebreak_addr = 64'h1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = RST_PC + 64'h100;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    n_cmp++; if (o_halted !== 1'b0 || o_rv !== 1'b1 || o_addr !== RST_PC + 64'h100) begin
      n_err++; $display("FAIL halt_restart got=%b/%b/%h want=0/1/%h", o_halted, o_rv, o_addr, RST_PC + 64'h100);
    end
  endtask
`else
  task automatic test_halt();
    int nf = 0, nh = 0;
    logic [31:0] ebw = '0;
    ebreak_addr = RST_PC + 64'd8;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (o_fire) nf++;
      if (o_halted) nh++;
      if (o_pop && o_pc == RST_PC + 64'd8) ebw = o_inst;
    end
    ebreak_addr = 64'h1;
    n_cmp++; if (ebw !== EBREAK) begin n_err++; $display("FAIL nohalt_ebreak_delivered got=%h want=%h", ebw, EBREAK); end
    n_cmp++; if (nh != 0 || nf != 8) begin n_err++; $display("FAIL nohalt_continue got=%0d/%0d want=0/8", nh, nf); end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_random();
    test_mid_reset();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
